// File: rtl/fc_inbuf_pingpong_ctrl_if.sv
// Handshake/bus bundle between the pool/flatten writer, the two input-neuron
// banks and the FC control block. Slave = the ping-pong controller.
// FC_INBUF_OVERRUN_CHK_EN adds the err_sticky status bit.
interface fc_inbuf_pingpong_ctrl_if #(
  parameter int DW  = 16,
  parameter int AW  = 8,
  parameter int PCW = 8
);
  logic           wr_valid;
  logic           wr_ready;
  logic [DW-1:0]  wr_data;
  logic [1:0]     bank_wren;
  logic [AW-1:0]  bank_wraddr;
  logic [DW-1:0]  bank_wrdata;
  logic           fc_start;
  logic           fc_bank_sel;
  logic           fc_done;
  logic [1:0]     bank_full;
  logic [PCW-1:0] pass_count;
`ifdef FC_INBUF_OVERRUN_CHK_EN
  logic           err_sticky;

  modport slave (
    input  wr_valid, wr_data, fc_done,
    output wr_ready, bank_wren, bank_wraddr, bank_wrdata,
           fc_start, fc_bank_sel, bank_full, pass_count, err_sticky
  );
  modport master (
    output wr_valid, wr_data, fc_done,
    input  wr_ready, bank_wren, bank_wraddr, bank_wrdata,
           fc_start, fc_bank_sel, bank_full, pass_count, err_sticky
  );
`else
  modport slave (
    input  wr_valid, wr_data, fc_done,
    output wr_ready, bank_wren, bank_wraddr, bank_wrdata,
           fc_start, fc_bank_sel, bank_full, pass_count
  );
  modport master (
    output wr_valid, wr_data, fc_done,
    input  wr_ready, bank_wren, bank_wraddr, bank_wrdata,
           fc_start, fc_bank_sel, bank_full, pass_count
  );
`endif
endinterface

// File: rtl/fc_inbuf_pingpong_ctrl.sv
// Ping-pong scheduler for the FC input-neuron buffer (two banks).
// Writer fills bank wr_sel while FC control consumes bank rd_sel; a full bank
// triggers a one-cycle fc_start, and fc_done releases it back to the writer.
// Optional: define FC_INBUF_OVERRUN_CHK_EN for the err_sticky overrun/protocol flag.
module fc_inbuf_pingpong_ctrl #(
  parameter int INNEURON               = 256,
  parameter int PI                     = 1,
  parameter int DATA_WIDTH_FC          = 16,
  parameter int FC_INNEURON_ADDR_WIDTH = 8,
  parameter int PASS_CNT_WIDTH         = 8
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  fc_inbuf_pingpong_ctrl_if.slave io_bus
);
  localparam int AW = FC_INNEURON_ADDR_WIDTH;
  localparam int DW = DATA_WIDTH_FC * PI;
  localparam logic [AW-1:0] LAST_ADDR = AW'(INNEURON / PI - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_RELEASE} state_t;

  state_t              r_state, w_next_state;
  logic                r_wr_sel, r_rd_sel;
  logic [AW-1:0]       r_wr_cnt;
  logic [1:0]          r_bank_full;
  logic [1:0]          r_bank_wren;
  logic [AW-1:0]       r_bank_wraddr;
  logic [DW-1:0]       r_bank_wrdata;
  logic [PASS_CNT_WIDTH-1:0] r_pass_cnt;

  logic       w_wr_ready, w_accept, w_wr_last, w_release;
  logic [1:0] w_set, w_clr;

  // Writer can push whenever its current bank is not holding a vector.
  assign w_wr_ready = !r_bank_full[r_wr_sel];
  assign w_accept   = io_bus.wr_valid && w_wr_ready;
  assign w_wr_last  = w_accept && (r_wr_cnt == LAST_ADDR);
  assign w_release  = (r_state == S_RELEASE);
  // Set and clear always hit different banks: the writer never targets a full bank.
  assign w_set      = w_wr_last ? (r_wr_sel ? 2'b10 : 2'b01) : 2'b00;
  assign w_clr      = w_release ? (r_rd_sel ? 2'b10 : 2'b01) : 2'b00;

  // Write side: one-cycle registered bank write, word counter and bank toggle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bank_wren   <= '0;
      r_bank_wraddr <= '0;
      r_bank_wrdata <= '0;
      r_wr_cnt      <= '0;
      r_wr_sel      <= 1'b0;
    end else begin
      r_bank_wren <= w_accept ? (r_wr_sel ? 2'b10 : 2'b01) : 2'b00;
      if (w_accept) begin
        r_bank_wraddr <= r_wr_cnt;
        r_bank_wrdata <= io_bus.wr_data;
      end
      if (w_wr_last) begin
        r_wr_cnt <= '0;
        r_wr_sel <= ~r_wr_sel;
      end else if (w_accept) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
      end
    end
  end

  // Bank ownership flags, read pointer and pass counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bank_full <= '0;
      r_rd_sel    <= 1'b0;
      r_pass_cnt  <= '0;
    end else begin
      r_bank_full <= (r_bank_full | w_set) & ~w_clr;
      if (w_release) begin
        r_rd_sel   <= ~r_rd_sel;
        r_pass_cnt <= r_pass_cnt + 1'b1;
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Read FSM next state; fc_done only matters while BUSY.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (r_bank_full[r_rd_sel]) w_next_state = S_START;
      S_START:   w_next_state = S_BUSY;
      S_BUSY:    if (io_bus.fc_done) w_next_state = S_RELEASE;
      S_RELEASE: w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

`ifdef FC_INBUF_OVERRUN_CHK_EN
  logic [AW-1:0] r_stall_cnt;
  logic          r_err;

  // Sticky error: writer stalled 2^AW consecutive cycles, or stray fc_done.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      if (io_bus.wr_valid && !w_wr_ready) begin
        if (&r_stall_cnt) r_err <= 1'b1;
        else              r_stall_cnt <= r_stall_cnt + 1'b1;
      end else begin
        r_stall_cnt <= '0;
      end
      if (io_bus.fc_done && (r_state != S_BUSY)) r_err <= 1'b1;
    end
  end

  assign io_bus.err_sticky = r_err;
`endif

  assign io_bus.wr_ready    = w_wr_ready;
  assign io_bus.bank_wren   = r_bank_wren;
  assign io_bus.bank_wraddr = r_bank_wraddr;
  assign io_bus.bank_wrdata = r_bank_wrdata;
  assign io_bus.fc_start    = (r_state == S_START);
  assign io_bus.fc_bank_sel = r_rd_sel;
  assign io_bus.bank_full   = r_bank_full;
  assign io_bus.pass_count  = r_pass_cnt;
endmodule

// File: tb/tb_fc_inbuf_pingpong_ctrl.sv
// Bench for fc_inbuf_pingpong_ctrl: directed scenarios drive the writer and
// fc_done; expected bank writes and fc_start banks are queued at issue time
// and a monitor thread pops/compares them when the DUT presents them.
module tb_fc_inbuf_pingpong_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic        tb_wr_valid = 1'b0;
  logic [15:0] tb_wr_data = '0;
  logic        tb_fc_done = 1'b0;

  fc_inbuf_pingpong_ctrl_if #(.DW(16), .AW(8), .PCW(8)) bus ();

  assign bus.wr_valid = tb_wr_valid;
  assign bus.wr_data  = tb_wr_data;
  assign bus.fc_done  = tb_fc_done;

  fc_inbuf_pingpong_ctrl #(
    .INNEURON(256), .PI(1), .DATA_WIDTH_FC(16),
    .FC_INNEURON_ADDR_WIDTH(8), .PASS_CNT_WIDTH(8)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wren;
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t  wq[$];
  logic sq[$];
  int   checks = 0;
  int   errors = 0;

  // bench model of the write-side / ownership state
  logic [1:0] m_full = '0;
  logic       m_wr_sel = 1'b0;
  logic       m_rd_sel = 1'b0;
  logic [7:0] m_wr_cnt = '0;
  logic [7:0] m_pass = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full = '0; m_wr_sel = 1'b0; m_rd_sel = 1'b0; m_wr_cnt = '0; m_pass = '0;
    wq.delete(); sq.delete();
  endtask

  task automatic model_release();
    m_full[m_rd_sel] = 1'b0;
    m_rd_sel = ~m_rd_sel;
    m_pass++;
  endtask

  // One writer cycle: present a word, predict acceptance, push expectations.
  task automatic send_word(input logic [15:0] d, output bit acc);
    logic rdy;
    tb_wr_valid = 1'b1;
    tb_wr_data  = d;
    rdy = !m_full[m_wr_sel];
    chk("wr_ready", 32'(bus.wr_ready), 32'(rdy));
    chk("bank_full", 32'(bus.bank_full), 32'(m_full));
    chk("pass_count", 32'(bus.pass_count), 32'(m_pass));
    if (rdy) begin
      wq.push_back('{wren: (m_wr_sel ? 2'b10 : 2'b01), addr: m_wr_cnt, data: d});
      if (m_wr_cnt == 8'd255) begin
        m_full[m_wr_sel] = 1'b1;
        sq.push_back(m_wr_sel);
        m_wr_sel = ~m_wr_sel;
        m_wr_cnt = '0;
      end else begin
        m_wr_cnt++;
      end
    end
    acc = rdy;
    @(posedge clk); #1;
  endtask

  task automatic put_word(input logic [15:0] d);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 1000) begin
      send_word(d, acc);
      tries++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL write_timeout data=%0h never accepted", d);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wren"},     32'(bus.bank_wren), 32'd0);
    chk({tag, "_wraddr"},   32'(bus.bank_wraddr), 32'd0);
    chk({tag, "_wrdata"},   32'(bus.bank_wrdata), 32'd0);
    chk({tag, "_fc_start"}, 32'(bus.fc_start), 32'd0);
    chk({tag, "_bank_sel"}, 32'(bus.fc_bank_sel), 32'd0);
    chk({tag, "_full"},     32'(bus.bank_full), 32'd0);
    chk({tag, "_pass"},     32'(bus.pass_count), 32'd0);
`ifdef FC_INBUF_OVERRUN_CHK_EN
    chk({tag, "_err"},      32'(bus.err_sticky), 32'd0);
`endif
  endtask

  // Scoreboard monitor: compare each presented write / start against the queues.
  task automatic monitor_loop();
    wr_t  e;
    logic b;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.bank_wren != 2'b00) begin
          if (wq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write wren=%b addr=%0d actual write required none", bus.bank_wren, bus.bank_wraddr);
          end else begin
            e = wq.pop_front();
            chk("wr_en",   32'(bus.bank_wren),   32'(e.wren));
            chk("wr_addr", 32'(bus.bank_wraddr), 32'(e.addr));
            chk("wr_data", 32'(bus.bank_wrdata), 32'(e.data));
          end
        end
        if (bus.fc_start) begin
          if (sq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_start bank=%0d actual pulse required none", bus.fc_bank_sel);
          end else begin
            b = sq.pop_front();
            chk("start_bank", 32'(bus.fc_bank_sel), 32'(b));
          end
        end
      end
    end
  endtask

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor_loop();
    join_none

    // Reset state
    #12;
    chk_reset_outputs("rst");
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: fill bank0 with continuous valid; fc_start 2 cycles after the last accept
    for (int i = 0; i < 256; i++) put_word(16'(16'h1000 + i));
    tb_wr_valid = 1'b0;
    chk("t1_full", 32'(bus.bank_full), 32'd1);
    @(negedge clk); chk("t1_start_early", 32'(bus.fc_start), 32'd0);
    @(negedge clk); chk("t1_start", 32'(bus.fc_start), 32'd1);
    chk("t1_bank_sel", 32'(bus.fc_bank_sel), 32'd0);
    @(posedge clk); #1;

    // 2: fill bank1, then writer stalls with no bank writes
    for (int i = 0; i < 256; i++) put_word(16'(16'h2000 + i));
    chk("t2_full", 32'(bus.bank_full), 32'd3);
    for (int i = 0; i < 4; i++) begin
      bit acc;
      send_word(16'hDEAD, acc);
    end
    tb_wr_valid = 1'b0;

    // 3: fc_done in BUSY releases bank0
    tb_fc_done = 1'b1;
    @(posedge clk); #1 tb_fc_done = 1'b0;
    @(posedge clk);
    model_release();
    #1;
    chk("t3_full", 32'(bus.bank_full), 32'd2);
    chk("t3_pass", 32'(bus.pass_count), 32'd1);
    chk("t3_bank_sel", 32'(bus.fc_bank_sel), 32'd1);
    chk("t3_wr_ready", 32'(bus.wr_ready), 32'd1);

    // 4: fc_done held through IDLE and START is ignored
    tb_fc_done = 1'b1;
    @(negedge clk); chk("t3_start_early", 32'(bus.fc_start), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("t3_start", 32'(bus.fc_start), 32'd1);
    @(posedge clk); #1 tb_fc_done = 1'b0;
    chk("t4_pass", 32'(bus.pass_count), 32'd1);
    chk("t4_full", 32'(bus.bank_full), 32'd2);
    chk("t4_bank_sel", 32'(bus.fc_bank_sel), 32'd1);
`ifdef FC_INBUF_OVERRUN_CHK_EN
    chk("t4_err", 32'(bus.err_sticky), 32'd1);
`endif

    // 5: bank0 completes on the same edge bank1 is released
    for (int i = 0; i < 254; i++) put_word(16'(16'h5000 + i));
    tb_fc_done = 1'b1;
    put_word(16'h50FE);
    tb_fc_done = 1'b0;
    put_word(16'h50FF);
    tb_wr_valid = 1'b0;
    model_release();
    chk("t5_full", 32'(bus.bank_full), 32'd1);
    chk("t5_pass", 32'(bus.pass_count), 32'd2);
    chk("t5_bank_sel", 32'(bus.fc_bank_sel), 32'd0);
    @(negedge clk); chk("t5_start_early", 32'(bus.fc_start), 32'd0);
    @(negedge clk); chk("t5_start", 32'(bus.fc_start), 32'd1);
    @(posedge clk); #1;

    // 6a: reset at word 100
    for (int i = 0; i < 100; i++) put_word(16'(16'h6000 + i));
    rst_n = 1'b0; tb_wr_valid = 1'b0;
    #1;
    chk_reset_outputs("t6a");
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 6b: refill from bank0 address 0, then reset while BUSY
    for (int i = 0; i < 256; i++) put_word(16'(16'h6100 + i));
    tb_wr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6b_full", 32'(bus.bank_full), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6b");
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 7: 257 passes with a concurrent fc_done responder
    fork
      begin
        for (int i = 0; i < 257 * 256; i++) put_word(16'(i * 7));
        tb_wr_valid = 1'b0;
      end
      begin
        bit to;
        to = 1'b0;
        for (int p = 0; p < 257 && !to; p++) begin
          int w;
          w = 0;
          @(negedge clk);
          while (!bus.fc_start && w < 2000) begin @(negedge clk); w++; end
          if (!bus.fc_start) begin
            checks++; errors++;
            $display("FAIL start_timeout pass=%0d no fc_start", p);
            to = 1'b1;
          end else begin
            @(posedge clk); #1 tb_fc_done = 1'b1;
            @(posedge clk); #1 tb_fc_done = 1'b0;
            @(posedge clk);
            model_release();
          end
        end
      end
    join
    #1;
    chk("t7_pass_wrap", 32'(bus.pass_count), 32'd1);
    chk("t7_full", 32'(bus.bank_full), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("wq_empty", 32'(wq.size()), 32'd0);
    chk("sq_empty", 32'(sq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
